// File: rtl/shift_reg_serializer.sv
`default_nettype none
// shift_reg_serializer: valid/ready parallel-to-serial transmitter, LSB- or MSB-first,
// with per-bit valid and frame strobes; back-to-back words are sent with no idle gap.
module shift_reg_serializer #(
  parameter int WIDTH      = 4,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             dir,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int                CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic             dir_q;
  logic             armed;

  logic             last_bit;
  logic             accept;

  assign last_bit = (state == SHIFT) && (cnt == LAST);

  // armed keeps load_ready low while reset is held and for the first edge after release
  assign load_ready = armed && ((state == IDLE) || (last_bit && shift_en));
  assign accept     = load_valid && load_ready;

  assign serial_valid = (state == SHIFT);
  assign busy         = (state == SHIFT);
  assign frame_start  = (state == SHIFT) && (cnt == '0);
  assign frame_end    = last_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      dir_q      <= 1'b0;
      armed      <= 1'b0;
      serial_out <= IDLE_LEVEL;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        state      <= SHIFT;
        cnt        <= '0;
        shreg      <= parallel_in;
        dir_q      <= dir;
        serial_out <= dir ? parallel_in[WIDTH-1] : parallel_in[0];
      end else if ((state == SHIFT) && shift_en) begin
        if (cnt == LAST) begin
          state      <= IDLE;
          cnt        <= '0;
          shreg      <= '0;
          serial_out <= IDLE_LEVEL;
        end else begin
          cnt <= cnt + 1'b1;
          // serial_out always mirrors the bit at the outgoing end of shreg
          if (dir_q) begin
            shreg      <= shreg << 1;
            serial_out <= shreg[WIDTH-2];
          end else begin
            shreg      <= shreg >> 1;
            serial_out <= shreg[1];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_serializer.sv
`default_nettype none
// Self-checking bench for shift_reg_serializer: directed scenarios plus randomized
// traffic compared against a word/bit-position reference model.
module tb_shift_reg_serializer;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] parallel_in;
  logic         dir;
  logic         shift_en;
  logic         serial_out;
  logic         serial_valid;
  logic         frame_start;
  logic         frame_end;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  shift_reg_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .parallel_in  (parallel_in),
    .dir          (dir),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; load_valid = 1'b1; parallel_in = 4'hF; dir = 1'b0; shift_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b0 || serial_out !== 1'b0 || serial_valid !== 1'b0 || busy !== 1'b0 ||
        frame_start !== 1'b0 || frame_end !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: ready=%b out=%b valid=%b busy=%b fs=%b fe=%b, expected all 0",
               load_ready, serial_out, serial_valid, busy, frame_start, frame_end);
    end
    reset = 1'b1; load_valid = 1'b0;
    tick();
    checks++;
    if (load_ready !== 1'b1 || serial_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b valid=%b, expected ready=1 valid=0", load_ready, serial_valid);
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;  // word bit i is expected in cycle i
    load_valid = 1'b1; parallel_in = 4'b1011; dir = 1'b0; shift_en = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL lsb_ready: load_ready=%b, expected 1", load_ready);
    end
    tick();
    load_valid = 1'b0; parallel_in = 4'b0100; dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (serial_out !== exp_bits[i] || serial_valid !== 1'b1 || busy !== 1'b1 ||
          frame_start !== (i == 0) || frame_end !== (i == 3)) begin
        failures++;
        $display("FAIL lsb_bit%0d: out=%b valid=%b fs=%b fe=%b, expected out=%b valid=1 fs=%b fe=%b",
                 i, serial_out, serial_valid, frame_start, frame_end, exp_bits[i], (i == 0), (i == 3));
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (serial_out !== 1'b0 || serial_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL lsb_idle: out=%b valid=%b busy=%b ready=%b, expected 0 0 0 1",
               serial_out, serial_valid, busy, load_ready);
    end
  endtask

  task automatic test_msb_first();
    logic [3:0] seq;
    logic [3:0] rx;
    seq = 4'b1101;  // cycle order 1,0,1,1
    rx  = '0;
    load_valid = 1'b1; parallel_in = 4'b1011; dir = 1'b1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0; parallel_in = 4'b0000; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (serial_out !== seq[i] || serial_valid !== 1'b1) begin
        failures++;
        $display("FAIL msb_bit%0d: out=%b valid=%b, expected out=%b valid=1", i, serial_out, serial_valid, seq[i]);
      end
      // receiving shift register takes each bit in at bit 0 and moves it toward the MSB
      rx = {rx[2:0], serial_out};
      tick();
    end
    checks++;
    if (rx !== 4'b1011) begin
      failures++;
      $display("FAIL msb_receiver: captured=%b, expected 1011", rx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    seq = 8'b0101_1111;  // cycle order 1,1,1,1,1,0,1,0
    load_valid = 1'b1; parallel_in = 4'b1111; dir = 1'b1; shift_en = 1'b1;
    tick();
    parallel_in = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (serial_out !== seq[i] || serial_valid !== 1'b1 || load_ready !== (i == 3 || i == 7) ||
          frame_start !== (i == 0 || i == 4) || frame_end !== (i == 3 || i == 7)) begin
        failures++;
        $display("FAIL b2b_bit%0d: out=%b valid=%b ready=%b fs=%b fe=%b, expected out=%b valid=1 ready=%b fs=%b fe=%b",
                 i, serial_out, serial_valid, load_ready, frame_start, frame_end,
                 seq[i], (i == 3 || i == 7), (i == 0 || i == 4), (i == 3 || i == 7));
      end
      tick();
      if (i == 3) load_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (serial_valid !== 1'b0 || serial_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: valid=%b out=%b, expected 0 0", serial_valid, serial_out);
    end
  endtask

  task automatic test_stall();
    logic [3:0] word;
    int         idx_seq [7];
    logic [6:0] en_pat;
    word    = 4'b0110;
    idx_seq = '{0, 1, 1, 1, 1, 2, 3};
    en_pat  = 7'b111_0001;
    load_valid = 1'b1; parallel_in = word; dir = 1'b0; shift_en = 1'b1;
    tick();
    parallel_in = 4'b1111; dir = 1'b1;
    for (int c = 0; c < 7; c++) begin
      shift_en   = en_pat[c];
      load_valid = (c >= 1 && c <= 3);
      @(negedge clk);
      checks++;
      if (serial_out !== word[idx_seq[c]] || serial_valid !== 1'b1 ||
          load_ready !== (c == 6) || frame_start !== (idx_seq[c] == 0) || frame_end !== (idx_seq[c] == 3)) begin
        failures++;
        $display("FAIL stall_c%0d: out=%b valid=%b ready=%b fs=%b fe=%b, expected out=%b valid=1 ready=%b fs=%b fe=%b",
                 c, serial_out, serial_valid, load_ready, frame_start, frame_end,
                 word[idx_seq[c]], (c == 6), (idx_seq[c] == 0), (idx_seq[c] == 3));
      end
      tick();
    end
    load_valid = 1'b0; shift_en = 1'b1;
    @(negedge clk);
    checks++;
    if (serial_valid !== 1'b0 || serial_out !== 1'b0) begin
      failures++;
      $display("FAIL stall_idle: valid=%b out=%b, expected 0 0", serial_valid, serial_out);
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] word2;
    load_valid = 1'b1; parallel_in = 4'b0100; dir = 1'b0; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (serial_out !== 1'b1 || serial_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre: out=%b valid=%b, expected 1 1", serial_out, serial_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (serial_out !== 1'b0 || serial_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_async: out=%b valid=%b busy=%b ready=%b, expected all 0",
               serial_out, serial_valid, busy, load_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    word2 = 4'b0110;
    load_valid = 1'b1; parallel_in = word2; dir = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (serial_out !== word2[3-i] || serial_valid !== 1'b1 || frame_start !== (i == 0)) begin
        failures++;
        $display("FAIL abort_reload_bit%0d: out=%b valid=%b fs=%b, expected out=%b valid=1 fs=%b",
                 i, serial_out, serial_valid, frame_start, word2[3-i], (i == 0));
      end
      tick();
    end
  endtask

  // Reference model: current word, its direction and the index of the bit on the wire (-1 = idle)
  task automatic test_random();
    int         m_pos;
    logic [3:0] m_word;
    logic       m_dir;
    logic       e_out, e_valid, e_ready, e_fs, e_fe;
    int         accepts;
    m_pos = -1; m_word = '0; m_dir = 1'b0; accepts = 0;
    for (int n = 0; n < 600; n++) begin
      load_valid  = 1'($urandom_range(0, 1));
      shift_en    = ($urandom_range(0, 3) != 0);
      parallel_in = 4'($urandom);
      dir         = 1'($urandom);
      @(negedge clk);
      e_valid = (m_pos >= 0);
      e_out   = (m_pos < 0) ? 1'b0 : (m_dir ? m_word[3-m_pos] : m_word[m_pos]);
      e_ready = (m_pos < 0) || (m_pos == 3 && shift_en);
      e_fs    = (m_pos == 0);
      e_fe    = (m_pos == 3);
      checks++;
      if (serial_out !== e_out || serial_valid !== e_valid || busy !== e_valid ||
          load_ready !== e_ready || frame_start !== e_fs || frame_end !== e_fe) begin
        failures++;
        $display("FAIL rand_cycle%0d: out=%b valid=%b busy=%b ready=%b fs=%b fe=%b, expected out=%b valid=%b busy=%b ready=%b fs=%b fe=%b",
                 n, serial_out, serial_valid, busy, load_ready, frame_start, frame_end,
                 e_out, e_valid, e_valid, e_ready, e_fs, e_fe);
      end
      if (load_valid && e_ready) begin
        m_word = parallel_in; m_dir = dir; m_pos = 0; accepts++;
      end else if (m_pos >= 0 && shift_en) begin
        m_pos = (m_pos == 3) ? -1 : m_pos + 1;
      end
      tick();
    end
    checks++;
    if (accepts < 20) begin
      failures++;
      $display("FAIL rand_activity: accepted words=%0d, expected at least 20", accepts);
    end
    load_valid = 1'b0; shift_en = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
